// File: rtl/pc_seq_pkg.sv
// Shared types and constants for the multicycle MIPS program-counter sequencer.
package pc_seq_pkg;

   typedef enum logic [1:0] {
      FETCH = 2'd0,
      EXEC  = 2'd1,
      HALT  = 2'd2
   } state_t;

   typedef enum logic [1:0] {
      ERR_NONE      = 2'b00,
      ERR_JR_ALIGN  = 2'b01,
      ERR_J_REGION  = 2'b10,
      ERR_TGT_ALIGN = 2'b11
   } err_t;

   localparam int unsigned PC_INC = 4;

endpackage

// File: rtl/pc_next_sel.sv
// Next-PC source selection (jr > jump > taken branch > sequential) and the
// target checks that apply to whichever source wins.
module pc_next_sel
   import pc_seq_pkg::*;
#(
   parameter int unsigned ADDR_W = 32
) (
   input  logic [ADDR_W-1:0] pc_plus4,
   input  logic              branch_en,
   input  logic              branch_taken,
   input  logic              jump_en,
   input  logic              jr_en,
   input  logic [ADDR_W-1:0] branch_offset,
   input  logic [ADDR_W-1:0] jump_target,
   input  logic [ADDR_W-1:0] jr_target,
   output logic [ADDR_W-1:0] next_pc,
   output err_t              err
);

   logic [ADDR_W-1:0] branch_target;

   assign branch_target = pc_plus4 + {branch_offset[ADDR_W-3:0], 2'b00};

   always_comb begin
      next_pc = pc_plus4;
      err     = ERR_NONE;
      if (jr_en) begin
         next_pc = jr_target;
         if (jr_target[1:0] != 2'b00) err = ERR_JR_ALIGN;
      end else if (jump_en) begin
         next_pc = jump_target;
         // Region must match pc+4: the upstream composition borrows those bits.
         if (jump_target[ADDR_W-1:ADDR_W-4] != pc_plus4[ADDR_W-1:ADDR_W-4])
            err = ERR_J_REGION;
         else if (jump_target[1:0] != 2'b00)
            err = ERR_TGT_ALIGN;
      end else if (branch_en && branch_taken) begin
         next_pc = branch_target;
         if (branch_target[1:0] != 2'b00) err = ERR_TGT_ALIGN;
      end
   end

endmodule

// File: rtl/pc_sequencer.sv
// Program counter owner: fetch handshake FSM, PC register and sticky
// error halt for the multicycle MIPS datapath.
module pc_sequencer
   import pc_seq_pkg::*;
#(
   parameter int unsigned       ADDR_W   = 32,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic              clk,
   input  logic              rst,
   output logic              fetch_valid,
   input  logic              fetch_ready,
   input  logic              instr_done,
   input  logic              branch_en,
   input  logic              branch_taken,
   input  logic              jump_en,
   input  logic              jr_en,
   input  logic [ADDR_W-1:0] branch_offset,
   input  logic [ADDR_W-1:0] jump_target,
   input  logic [ADDR_W-1:0] jr_target,
   output logic [ADDR_W-1:0] pc,
   output logic [ADDR_W-1:0] pc_plus4,
   output logic              halted,
   output logic [1:0]        err_code
);

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] pc_q;
   logic [ADDR_W-1:0] next_pc;
   err_t              sel_err;
   err_t              err_q;
   logic              halted_q;
   logic              commit;

   assign pc_plus4 = pc_q + ADDR_W'(PC_INC);
   assign commit   = (state_q == EXEC) && instr_done;

   pc_next_sel #(.ADDR_W(ADDR_W)) u_next_sel (
      .pc_plus4      (pc_plus4),
      .branch_en     (branch_en),
      .branch_taken  (branch_taken),
      .jump_en       (jump_en),
      .jr_en         (jr_en),
      .branch_offset (branch_offset),
      .jump_target   (jump_target),
      .jr_target     (jr_target),
      .next_pc       (next_pc),
      .err           (sel_err)
   );

   always_ff @(posedge clk) begin
      if (rst) state_q <= FETCH;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         FETCH:   if (fetch_ready) state_d = EXEC;
         EXEC:    if (instr_done)  state_d = (sel_err != ERR_NONE) ? HALT : FETCH;
         HALT:    state_d = HALT;
         default: state_d = FETCH;
      endcase
   end

   always_comb begin
      fetch_valid = (state_q == FETCH);
   end

   // A faulting commit leaves pc at the faulting instruction's address.
   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q     <= RESET_PC;
         halted_q <= 1'b0;
         err_q    <= ERR_NONE;
      end else if (commit) begin
         if (sel_err == ERR_NONE) begin
            pc_q <= next_pc;
         end else begin
            halted_q <= 1'b1;
            err_q    <= sel_err;
         end
      end
   end

   assign pc       = pc_q;
   assign halted   = halted_q;
   assign err_code = err_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed-vector bench for pc_sequencer with hand-computed expectations.
module tb_pc_sequencer;

   logic        clk = 1'b0;
   logic        rst;
   logic        fetch_valid;
   logic        fetch_ready;
   logic        instr_done;
   logic        branch_en;
   logic        branch_taken;
   logic        jump_en;
   logic        jr_en;
   logic [31:0] branch_offset;
   logic [31:0] jump_target;
   logic [31:0] jr_target;
   logic [31:0] pc;
   logic [31:0] pc_plus4;
   logic        halted;
   logic [1:0]  err_code;

   int unsigned n_vec = 0;
   int unsigned n_bad = 0;

   pc_sequencer #(.ADDR_W(32), .RESET_PC(32'h0000_0000)) dut (
      .clk           (clk),
      .rst           (rst),
      .fetch_valid   (fetch_valid),
      .fetch_ready   (fetch_ready),
      .instr_done    (instr_done),
      .branch_en     (branch_en),
      .branch_taken  (branch_taken),
      .jump_en       (jump_en),
      .jr_en         (jr_en),
      .branch_offset (branch_offset),
      .jump_target   (jump_target),
      .jr_target     (jr_target),
      .pc            (pc),
      .pc_plus4      (pc_plus4),
      .halted        (halted),
      .err_code      (err_code)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_ctl();
      instr_done    = 1'b0;
      branch_en     = 1'b0;
      branch_taken  = 1'b0;
      jump_en       = 1'b0;
      jr_en         = 1'b0;
      branch_offset = '0;
      jump_target   = '0;
      jr_target     = '0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step();
      rst = 1'b0;
   endtask

   // Fetch handshake, then one instr_done pulse carrying the given redirect.
   task automatic run_instr(input logic jr, input logic j, input logic b, input logic bt,
                            input logic [31:0] off, input logic [31:0] jt, input logic [31:0] jrt);
      for (int i = 0; i < 20 && !fetch_valid; i++) step();
      if (!fetch_valid) check("fetch_wait_timeout", 32'(fetch_valid), 32'd1);
      fetch_ready = 1'b1;
      step();
      fetch_ready = 1'b0;
      check("exec_fetch_valid_low", 32'(fetch_valid), 32'd0);
      instr_done    = 1'b1;
      jr_en         = jr;
      jump_en       = j;
      branch_en     = b;
      branch_taken  = bt;
      branch_offset = off;
      jump_target   = jt;
      jr_target     = jrt;
      step();
      clear_ctl();
   endtask

   initial begin
      rst = 1'b1;
      fetch_ready = 1'b0;
      clear_ctl();
      step();
      step();
      check("rst_pc", pc, 32'h0);
      check("rst_halted", 32'(halted), 32'd0);
      check("rst_err", 32'(err_code), 32'd0);
      rst = 1'b0;
      check("post_rst_fetch_valid", 32'(fetch_valid), 32'd1);

      // Sequential fetch
      run_instr(0, 0, 0, 0, '0, '0, '0);
      check("seq_pc4", pc, 32'h4);
      check("seq_fetch_valid_back", 32'(fetch_valid), 32'd1);
      run_instr(0, 0, 0, 0, '0, '0, '0);
      check("seq_pc8", pc, 32'h8);
      check("seq_pc_plus4", pc_plus4, 32'hC);

      // Jump within region, then region mismatch
      run_instr(1, 0, 0, 0, '0, '0, 32'h8000_0000);
      check("jr_to_8000", pc, 32'h8000_0000);
      run_instr(0, 1, 0, 0, '0, 32'h8FF0_38EC, '0);
      check("jump_ok", pc, 32'h8FF0_38EC);
      run_instr(0, 1, 0, 0, '0, 32'h1000_0000, '0);
      check("jregion_halted", 32'(halted), 32'd1);
      check("jregion_err", 32'(err_code), 32'd2);
      check("jregion_pc_held", pc, 32'h8FF0_38EC);
      check("halt_fetch_valid", 32'(fetch_valid), 32'd0);
      do_reset();

      // Branch taken backwards, then not taken
      run_instr(1, 0, 0, 0, '0, '0, 32'h10);
      run_instr(0, 0, 1, 1, 32'hFFFF_FFFE, '0, '0);
      check("branch_taken", pc, 32'hC);
      run_instr(1, 0, 0, 0, '0, '0, 32'h10);
      run_instr(0, 0, 1, 0, 32'hFFFF_FFFE, '0, '0);
      check("branch_not_taken", pc, 32'h14);

      // Jump beats branch
      run_instr(0, 1, 1, 1, 32'h0000_0010, 32'h0000_0200, '0);
      check("prio_jump_over_branch", pc, 32'h200);

      // jr beats everything; losing sources are not checked
      run_instr(1, 1, 1, 1, 32'h1, 32'h1000_0001, 32'h40);
      check("prio_jr", pc, 32'h40);
      check("prio_no_err", 32'(halted), 32'd0);
      run_instr(1, 1, 1, 1, 32'h1, 32'h0000_0080, 32'h42);
      check("jr_align_err", 32'(err_code), 32'd1);
      check("jr_align_halted", 32'(halted), 32'd1);
      check("jr_align_pc_held", pc, 32'h40);
      instr_done = 1'b1;
      jr_en      = 1'b1;
      jr_target  = 32'h100;
      fetch_ready = 1'b1;
      for (int i = 0; i < 3; i++) step();
      clear_ctl();
      fetch_ready = 1'b0;
      check("halt_ignores_done_pc", pc, 32'h40);
      check("halt_ignores_done_fv", 32'(fetch_valid), 32'd0);
      check("halt_err_sticky", 32'(err_code), 32'd1);
      do_reset();

      // Misaligned jump target
      run_instr(0, 1, 0, 0, '0, 32'h0000_0102, '0);
      check("jalign_err", 32'(err_code), 32'd3);
      check("jalign_pc_held", pc, 32'h0);
      do_reset();

      // Stall with instr_done during FETCH, then reset from EXEC
      run_instr(1, 0, 0, 0, '0, '0, 32'h100);
      instr_done = 1'b1;
      jr_en      = 1'b1;
      jr_target  = 32'h200;
      for (int i = 0; i < 5; i++) begin
         step();
         check("stall_fetch_valid", 32'(fetch_valid), 32'd1);
         check("stall_pc", pc, 32'h100);
      end
      clear_ctl();
      fetch_ready = 1'b1;
      step();
      fetch_ready = 1'b0;
      check("accept_exec", 32'(fetch_valid), 32'd0);
      rst        = 1'b1;
      instr_done = 1'b1;
      jr_en      = 1'b1;
      jr_target  = 32'h300;
      step();
      rst = 1'b0;
      clear_ctl();
      check("exec_rst_pc", pc, 32'h0);
      check("exec_rst_fetch", 32'(fetch_valid), 32'd1);
      check("exec_rst_halted", 32'(halted), 32'd0);

      // Sequential wrap ignores region
      run_instr(1, 0, 0, 0, '0, '0, 32'hFFFF_FFFC);
      check("wrap_pre", pc, 32'hFFFF_FFFC);
      check("wrap_pc_plus4", pc_plus4, 32'h0);
      run_instr(0, 0, 0, 0, '0, 32'h1234_0001, '0);
      check("wrap_pc", pc, 32'h0);
      check("wrap_no_halt", 32'(halted), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
